radio_serial_deframer: RTL

//  Receive-side deframer for the radio_0 link. It consumes the 1-bit serial stream from the HSMC

---
 rtl/radio_serial_deframer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/radio_serial_deframer.sv
// Serial sync-hunting deframer: finds SYNC_WORD in a 1-bit stream, deserialises a
// fixed-length frame into words and queues them on an Avalon-ST source with SOP/EOP.
module radio_serial_deframer #(
  parameter int unsigned       SYNC_W      = 32,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = 32'h1ACFFC1D,
  parameter int unsigned       WORD_W      = 32,
  parameter int unsigned       FRAME_WORDS = 4,
  parameter int unsigned       FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_serial_data,
  input  logic              rx_bit_en,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              locked,
  output logic [7:0]        frame_count,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int unsigned BCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned IDX_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = WORD_W + 2;

  typedef enum logic {ST_HUNT, ST_PAYLOAD} state_t;

  state_t            r_state;
  logic [SYNC_W-2:0] r_sr;
  logic [WORD_W-2:0] r_wsr;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [IDX_W-1:0]  r_word_idx;
  logic [7:0]        r_frame_count;
  logic              r_overflow;

  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [SYNC_W-1:0] w_sr_next;
  logic [WORD_W-1:0] w_word;
  logic              w_word_done;
  logic              w_first;
  logic              w_last;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;

  assign w_sr_next   = {r_sr, rx_serial_data};
  assign w_word      = {r_wsr, rx_serial_data};
  assign w_word_done = (r_state == ST_PAYLOAD) && rx_bit_en &&
                       (r_bit_cnt == BCNT_W'(WORD_W - 1));
  assign w_first     = (r_word_idx == '0);
  assign w_last      = (r_word_idx == IDX_W'(FRAME_WORDS - 1));
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push      = w_word_done && !w_full;
  assign w_pop       = out_valid && out_ready;

  assign w_head      = r_mem[r_rd_ptr];
  assign out_data    = w_head[ENT_W-1:2];
  assign out_sop     = w_head[1];
  assign out_eop     = w_head[0];
  assign out_valid   = (r_count != '0);
  assign locked      = (r_state == ST_PAYLOAD);
  assign frame_count = r_frame_count;
  assign overflow    = r_overflow;

  // Hunt / payload sequencing; only advances on bit strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_HUNT;
      r_sr          <= '0;
      r_wsr         <= '0;
      r_bit_cnt     <= '0;
      r_word_idx    <= '0;
      r_frame_count <= '0;
    end else if (rx_bit_en) begin
      case (r_state)
        ST_HUNT: begin
          r_sr <= w_sr_next[SYNC_W-2:0];
          if (w_sr_next == SYNC_WORD) begin
            r_state   <= ST_PAYLOAD;
            r_bit_cnt <= '0;
          end
        end
        ST_PAYLOAD: begin
          r_wsr <= w_word[WORD_W-2:0];
          if (w_word_done) begin
            r_bit_cnt <= '0;
            if (w_last) begin
              // Clearing the hunt register keeps payload bits from forming a false sync.
              r_state       <= ST_HUNT;
              r_sr          <= '0;
              r_word_idx    <= '0;
              r_frame_count <= r_frame_count + 8'd1;
            end else begin
              r_word_idx <= r_word_idx + IDX_W'(1);
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  // Sticky overflow; a drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_word_done && w_full) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Show-ahead output FIFO holding {data, sop, eop}.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_word, w_first, w_last};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
